// File: rtl/alk_pkg.sv
// Shared definitions for the ALK micro-flag bank: flag op encodings and a
// constant-foldable ceil(log2) helper used to size selectors and counters.
package alk_pkg;

  typedef enum logic [2:0] {
    ALKF_HOLD  = 3'b000,
    ALKF_ADD   = 3'b001,
    ALKF_SUB   = 3'b010,
    ALKF_SHIFT = 3'b011,
    ALKF_CLR   = 3'b100,
    ALKF_SET   = 3'b101,
    ALKF_INV   = 3'b110,
    ALKF_HOLD2 = 3'b111
  } alk_op_e;

  // Smallest r with 2**r >= n (0 for n <= 1).
  function automatic int alk_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alk_uflag_bank_if.sv
// Micro-op / status bundle between the ALU control decode and the flag bank.
// master = microcode/decode side, slave = the flag bank itself.
interface alk_uflag_bank_if
  import alk_pkg::*;
#(
  parameter int NFLAGS = 4,
  parameter int DEPTH  = 4
);
  localparam int SELW = (alk_clog2(NFLAGS) < 1) ? 1 : alk_clog2(NFLAGS);
  localparam int DW   = alk_clog2(DEPTH + 1);

  logic              long_lit_l;
  logic [SELW-1:0]   flag_sel_h;
  alk_op_e           op_h;
  logic              c32_in_h;
  logic              alu_sout_shr_h;
  logic              push_h;
  logic              pop_h;
  logic              clr_err_h;
  logic [NFLAGS-1:0] flags_h;
  logic              sel_flag_h;
  logic [DW-1:0]     stk_depth_h;
  logic              stk_ovf_h;
  logic              stk_unf_h;

  modport master (
    output long_lit_l, flag_sel_h, op_h, c32_in_h, alu_sout_shr_h,
           push_h, pop_h, clr_err_h,
    input  flags_h, sel_flag_h, stk_depth_h, stk_ovf_h, stk_unf_h
  );

  modport slave (
    input  long_lit_l, flag_sel_h, op_h, c32_in_h, alu_sout_shr_h,
           push_h, pop_h, clr_err_h,
    output flags_h, sel_flag_h, stk_depth_h, stk_ovf_h, stk_unf_h
  );

endinterface

// File: rtl/alk_uflag_stack.sv
// Saturating LIFO for flag-vector save/restore. Simultaneous push and pop is
// a no-op; error outputs are single-cycle events, made sticky by the caller.
module alk_uflag_stack
  import alk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int DW   = alk_clog2(DEPTH + 1),
  localparam int AW   = (alk_clog2(DEPTH) < 1) ? 1 : alk_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             pop_ok,
  output logic             ovf_ev,
  output logic             unf_ev
);

  logic [DW-1:0]    depth_q, depth_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_v, pop_v, full, empty, push_ok;

  // Qualify requests against occupancy and compute the next depth.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    depth_d = depth_q;
    push_v  = push & ~pop;
    pop_v   = pop & ~push;
    full    = (depth_q == DW'(DEPTH));
    empty   = (depth_q == '0);
    push_ok = push_v & ~full;
    pop_ok  = pop_v & ~empty;
    ovf_ev  = push_v & full;
    unf_ev  = pop_v & empty;
    if (push_ok)     depth_d = depth_q + DW'(1);
    else if (pop_ok) depth_d = depth_q - DW'(1);
  end

  // Depth counter; reset empties the stack logically.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (!rst_n) depth_q <= '0;
    else        depth_q <= depth_d;
  end

  // Entry storage, written at the current depth on an accepted push.
  // NOTE: contents are deliberately not reset; depth alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[AW'(depth_q)] <= wdata;
  end

  assign top   = mem_q[AW'(depth_q - DW'(1))];
  assign depth = depth_q;

endmodule

// File: rtl/alk_uflag_bank.sv
// ALK micro-flag bank: NFLAGS independent carry/link flags with per-cycle
// single-flag ops, a save/restore stack and sticky stack-error flags.
module alk_uflag_bank
  import alk_pkg::*;
#(
  parameter int                NFLAGS    = 4,
  parameter int                DEPTH     = 4,
  parameter logic [NFLAGS-1:0] RESET_VAL = '0,
  localparam int SELW = (alk_clog2(NFLAGS) < 1) ? 1 : alk_clog2(NFLAGS),
  localparam int DW   = alk_clog2(DEPTH + 1)
) (
  input  logic           qdclk_l,
  input  logic           reset_l,
  alk_uflag_bank_if.slave bus
);

  logic [NFLAGS-1:0] flags_q, flags_d, base;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              en, sel_flag;
  logic [NFLAGS-1:0] stk_top;
  logic [DW-1:0]     stk_depth;
  logic              pop_ok, ovf_ev, unf_ev;

  assign en = bus.long_lit_l;

  alk_uflag_stack #(
    .WIDTH (NFLAGS),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk    (qdclk_l),
    .rst_n  (reset_l),
    .push   (bus.push_h & en),
    .pop    (bus.pop_h & en),
    .wdata  (flags_q),
    .top    (stk_top),
    .depth  (stk_depth),
    .pop_ok (pop_ok),
    .ovf_ev (ovf_ev),
    .unf_ev (unf_ev)
  );

  // Pick the base vector (restored or current), apply the op to the selected
  // flag, and fold stack errors into the stickies with clear taking priority.
  always_comb begin
    base     = pop_ok ? stk_top : flags_q;
    flags_d  = base;
    sel_flag = 1'b0;
    for (int i = 0; i < NFLAGS; i++) begin
      if (SELW'(i) == bus.flag_sel_h) begin
        sel_flag = flags_q[i];
        if (en) begin
          case (bus.op_h)
            ALKF_ADD:   flags_d[i] = bus.c32_in_h;
            ALKF_SUB:   flags_d[i] = ~bus.c32_in_h;
            ALKF_SHIFT: flags_d[i] = bus.alu_sout_shr_h;
            ALKF_CLR:   flags_d[i] = 1'b0;
            ALKF_SET:   flags_d[i] = 1'b1;
            ALKF_INV:   flags_d[i] = ~base[i];
            default:    flags_d[i] = base[i];
          endcase
        end
      end
    end
    ovf_d = bus.clr_err_h ? 1'b0 : (ovf_q | ovf_ev);
    unf_d = bus.clr_err_h ? 1'b0 : (unf_q | unf_ev);
  end

  // Flag vector and sticky error registers.
  always_ff @(posedge qdclk_l or negedge reset_l) begin
    if (!reset_l) begin
      flags_q <= RESET_VAL;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.flags_h     = flags_q;
  assign bus.sel_flag_h  = sel_flag;
  assign bus.stk_depth_h = stk_depth;
  assign bus.stk_ovf_h   = ovf_q;
  assign bus.stk_unf_h   = unf_q;

endmodule
